// File: rtl/sound_pkg.sv
// Shared definitions for the sound effect sequencer: note prescaler
// constants, the sequencer state encoding and the built-in effect table.
package sound_pkg;

    // Tone prescaler values for a 25 MHz clock, one octave starting at C4
    localparam logic [9:0] REST  = 10'h000;
    localparam logic [9:0] DO    = 10'h175;
    localparam logic [9:0] RE    = 10'h14D;
    localparam logic [9:0] MI    = 10'h128;
    localparam logic [9:0] FA    = 10'h118;
    localparam logic [9:0] SOL   = 10'h0F9;
    localparam logic [9:0] LA    = 10'h0DD;
    localparam logic [9:0] SI    = 10'h0C6;
    localparam logic [9:0] DO_HI = 10'h0BB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } fx_state_e;

    // Shape of the built-in effect table; a REST entry terminates an effect
    localparam int FX_CH    = 3;
    localparam int FX_NOTES = 4;

    localparam logic [9:0] FX_TABLE [FX_CH][FX_NOTES] = '{
        '{DO, REST, REST, REST},
        '{LA, MI,   DO,   REST},
        '{MI, MI,   REST, REST}
    };

endpackage

// File: rtl/priority_arbiter.sv
// Fixed-priority picker: reports the lowest-index set bit of the pending vector.
module priority_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending_i,
    output logic [IDX_W-1:0] grantIdx_o,
    output logic             grantValid_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        grantIdx_o   = '0;
        grantValid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                grantIdx_o   = IDX_W'(i);
                grantValid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_effect_sequencer.sv
// Plays short multi-note sound effects requested on prioritised channels,
// driving a tone prescaler value and an enable with fixed note/gap timing.
module sound_effect_sequencer
    import sound_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int NOTES_PER_FX = 4,
    parameter int NOTE_TICKS   = 2_500_000,
    parameter int GAP_TICKS    = 250_000,
    parameter int PREEMPT      = 1
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUM_CH-1:0]         audioRequest,
    output logic [9:0]                preScaleValue,
    output logic                      soundEnable,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] activeCh
);

    localparam int CH_W      = $clog2(NUM_CH);
    localparam int IDX_W     = (NOTES_PER_FX > 1) ? $clog2(NOTES_PER_FX) : 1;
    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] NOTE_LOAD   = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_TICKS - 1);
    localparam bit               CAN_PREEMPT = (PREEMPT != 0);

    fx_state_e          state_q, state_d;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [9:0]         preScale_q, preScale_d;
    logic               soundEn_q, soundEn_d;
    logic               busy_q, busy_d;
    logic [CH_W-1:0]    activeCh_q, activeCh_d;

    logic [CH_W-1:0]    arbIdx;
    logic               arbValid;
    logic               startFx;
    logic [NUM_CH-1:0]  clrMask;
    int                 nextIdx;

    // Table entries outside the built-in table or the configured shape read as REST
    function automatic logic [9:0] noteAt(input int ch, input int idx);
        logic [9:0] note;
        note = REST;
        for (int c = 0; c < FX_CH; c++) begin
            for (int n = 0; n < FX_NOTES; n++) begin
                if (c == ch && n == idx && c < NUM_CH && n < NOTES_PER_FX) begin
                    note = FX_TABLE[c][n];
                end
            end
        end
        return note;
    endfunction

    priority_arbiter #(
        .N     (NUM_CH),
        .IDX_W (CH_W)
    ) uArbiter (
        .pending_i    (pending_q),
        .grantIdx_o   (arbIdx),
        .grantValid_o (arbValid)
    );

    // Next-state logic: start/preempt decisions, note/gap timing and the output values
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        clrMask    = '0;
        startFx    = 1'b0;
        nextIdx    = int'(idx_q) + 1;

        case (state_q)
            IDLE: begin
                startFx = arbValid;
            end
            PLAY: begin
                if (CAN_PREEMPT && arbValid && (arbIdx < ch_q)) begin
                    startFx = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (CAN_PREEMPT && arbValid && (arbIdx < ch_q)) begin
                    startFx = 1'b1;
                end else if (cnt_q == '0) begin
                    if (nextIdx >= NOTES_PER_FX || noteAt(int'(ch_q), nextIdx) == REST) begin
                        state_d = IDLE;
                        ch_d    = '0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = PLAY;
                        idx_d   = IDX_W'(nextIdx);
                        cnt_d   = NOTE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Starting an effect (fresh or preempting) always begins at note 0;
        // an effect whose first entry is REST ends before making any sound
        if (startFx) begin
            clrMask = NUM_CH'(1) << arbIdx;
            idx_d   = '0;
            if (noteAt(int'(arbIdx), 0) == REST) begin
                state_d = IDLE;
                ch_d    = '0;
                cnt_d   = '0;
            end else begin
                state_d = PLAY;
                ch_d    = arbIdx;
                cnt_d   = NOTE_LOAD;
            end
        end

        // A new request in the same cycle as its channel starting keeps it pending
        pending_d = (pending_q & ~clrMask) | audioRequest;

        preScale_d = (state_d == PLAY) ? noteAt(int'(ch_d), int'(idx_d)) : REST;
        soundEn_d  = (state_d == PLAY);
        busy_d     = (state_d != IDLE);
        activeCh_d = (state_d != IDLE) ? ch_d : '0;
    end

    // State, pending requests and registered outputs; reset wipes everything
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            ch_q       <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            preScale_q <= '0;
            soundEn_q  <= 1'b0;
            busy_q     <= 1'b0;
            activeCh_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ch_q       <= ch_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            preScale_q <= preScale_d;
            soundEn_q  <= soundEn_d;
            busy_q     <= busy_d;
            activeCh_q <= activeCh_d;
        end
    end

    assign preScaleValue = preScale_q;
    assign soundEnable   = soundEn_q;
    assign busy          = busy_q;
    assign activeCh      = activeCh_q;

endmodule

// File: doc/sound_effect_sequencer.md
SOUND_EFFECT_SEQUENCER -- requirements
Module: sound_effect_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning the number of sound-request channels, where channel 0 has the highest priority.
REQ-002 The block SHALL have parameter NOTES_PER_FX, default 4, meaning the maximum number of notes in one effect.
REQ-003 The block SHALL have parameter NOTE_TICKS, default 2_500_000, meaning the clock cycles each note sounds (100 ms at 25 MHz).
REQ-004 The block SHALL have parameter GAP_TICKS, default 250_000, meaning the silent clock cycles between consecutive notes.
REQ-005 The block SHALL have parameter PREEMPT, default 1, meaning a higher-priority request aborts the current effect when set to 1.
REQ-006 The block SHALL have port clk, input, width 1: the single system clock.
REQ-007 The block SHALL have port resetN, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port audioRequest, input, width NUM_CH: per-channel request, sampled on every rising edge.
REQ-009 The block SHALL have port preScaleValue, output, width 10: the tone prescaler value, 0 when silent.
REQ-010 The block SHALL have port soundEnable, output, width 1: high while a note is sounding.
REQ-011 The block SHALL have port busy, output, width 1: high in PLAY or GAP.
REQ-012 The block SHALL have port activeCh, output, width $clog2(NUM_CH): the channel currently playing, 0 when idle.

Function
REQ-013 Each audioRequest bit sampled high SHALL set that channel's pending bit; requests are level-or-pulse tolerant, and pending is sticky until the effect starts.
REQ-014 The FSM SHALL have exactly three states: IDLE, PLAY and GAP.
REQ-015 In IDLE with any pending bit set, the FSM SHALL, at the next edge, select the lowest-index pending channel, clear its pending bit, load note index 0 and enter PLAY.
REQ-016 When a request and the start of the same channel coincide, the set SHALL win, so pending stays 1 and the effect replays afterwards.
REQ-017 In PLAY, preScaleValue SHALL equal the table entry [ch][idx] and soundEnable SHALL be 1 for exactly NOTE_TICKS cycles; the FSM then enters GAP.
REQ-018 In GAP, preScaleValue SHALL be 0 and soundEnable SHALL be 0 for GAP_TICKS cycles.
REQ-019 At the end of GAP, idx SHALL increment; if idx reaches NOTES_PER_FX or the next entry is 0 (terminator), the FSM SHALL return to IDLE, otherwise it re-enters PLAY.
REQ-020 A 0 entry at index 0 SHALL make the effect skip straight to IDLE with no sound.
REQ-021 With PREEMPT=1, a pending channel of lower index than activeCh in PLAY or GAP SHALL, at the next edge, abort the current effect (which is not re-queued) and start the new one at idx 0 in PLAY.
REQ-022 With PREEMPT=0, pending requests SHALL wait for IDLE.
REQ-023 All outputs SHALL be registered; the first note SHALL appear 2 cycles after the request edge (1 cycle to pending, 1 cycle to PLAY).
REQ-024 The tick counter SHALL be sized $clog2(max(NOTE_TICKS,GAP_TICKS)+1) and SHALL reload on every state change, including preemption.

Reset
REQ-025 When resetN is low, the block SHALL asynchronously force state=IDLE, pending=0, idx=0, counter=0, preScaleValue=0, soundEnable=0, busy=0 and activeCh=0.
REQ-026 Reset asserted mid-effect SHALL drop all pending requests, and no effect SHALL resume after release.

Structure
REQ-027 Package sound_pkg SHALL hold the note constants (DO=10'h175, MI=10'h128, LA=10'h0DD and the remaining 25 MHz octave values), the state enum, and the default effect table: ch0 {DO,0,0,0}, ch1 {LA,MI,DO,0}, ch2 {MI,MI,0,0}.
REQ-028 The table SHALL be a package constant indexed [NUM_CH][NOTES_PER_FX], and sound_effect_sequencer SHALL consume it read-only.
REQ-029 One sub-module, priority_arbiter (NUM_CH-bit pending in, index and valid out), SHALL be instantiated.

Verification (NOTE_TICKS=4, GAP_TICKS=1)
REQ-030 A 1-cycle pulse on ch1 SHALL produce 10'h0DD×4, 0×1, 10'h128×4, 0×1, 10'h175×4, 0×1 and then IDLE with busy=0.
REQ-031 ch0 and ch2 raised in the same cycle SHALL play ch0 (10'h175×4, gap) first, then ch2 (10'h128×4, gap, 10'h128×4, gap).
REQ-032 With PREEMPT=1, ch0 raised in the 2nd PLAY cycle of ch2 SHALL switch preScaleValue to 10'h175 one cycle later with activeCh=0, and ch2 SHALL NOT resume.
REQ-033 With PREEMPT=0 in the same scenario, ch2 SHALL complete, then ch0 SHALL play.
REQ-034 resetN pulsed low mid-note of ch1 with ch2 pending SHALL immediately give outputs 0, and the block SHALL stay IDLE after release.
REQ-035 ch1 re-requested during its own GAP SHALL replay ch1 from idx 0 right after it finishes.
